byte_mem_ctrl: RTL and testbench



---
 rtl/byte_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_byte_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl: byte-addressable memory with per-lane byte enables, selectable byte order and registered reads.
// Optional feature: define BMEM_CLEAR_EN to compile in the clear sequencer that zeroes the array after every reset.
module byte_mem_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  input  logic [DATA_BYTES-1:0]   be,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_BYTES - 1);

  logic [7:0]              mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0]   lane_addr_s [DATA_BYTES];
  logic [8*DATA_BYTES-1:0] rd_word_s;
  logic [8*DATA_BYTES-1:0] rdata_r;
  logic                    rvalid_r;
  logic                    err_r;
  logic                    busy_s;
  logic                    clear_we_s;
  logic [ADDR_WIDTH-1:0]   clear_base_s;
  logic                    req_s;
  logic                    acc_wr_s;
  logic                    acc_rd_s;
  logic                    err_next_s;

  // Per-lane byte address (wraps modulo the array size) and the assembled read word
  always_comb begin
    lane_addr_s = '{default: '0};
    rd_word_s   = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (BIG_ENDIAN) begin
        lane_addr_s[k] = addr + ADDR_WIDTH'(DATA_BYTES - 1 - k);
      end else begin
        lane_addr_s[k] = addr + ADDR_WIDTH'(k);
      end
      rd_word_s[8*k +: 8] = mem_r[lane_addr_s[k]];
    end
  end

  // Request qualification; a combined rd+wr performs only the write
  always_comb begin
    req_s      = cs && (rd || wr) && !reset;
    acc_wr_s   = req_s && !busy_s && wr;
    acc_rd_s   = req_s && !busy_s && rd && !wr;
    err_next_s = req_s && (busy_s || (rd && wr) || ((addr & ALIGN_MASK) != '0));
  end

  // Registered read data, read strobe and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= acc_rd_s;
      err_r    <= err_next_s;
      if (acc_rd_s) begin
        rdata_r <= rd_word_s;
      end
    end
  end

  // Array update: clear words take priority, otherwise enabled lanes of an accepted write
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        mem_r[clear_base_s + ADDR_WIDTH'(k)] <= 8'h00;
      end
    end else if (acc_wr_s) begin
      for (int k = 0; k < DATA_BYTES; k++) begin
        if (be[k]) begin
          mem_r[lane_addr_s[k]] <= wdata[8*k +: 8];
        end
      end
    end
  end

`ifdef BMEM_CLEAR_EN
  localparam int LSB_W = $clog2(DATA_BYTES);
  localparam int CNT_W = ADDR_WIDTH - LSB_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'((DEPTH >> LSB_W) - 1);

  typedef enum logic [0:0] {ST_READY = 1'b0, ST_CLEAR = 1'b1} state_t;
  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Sequencer state and word counter; every reset restarts the clear from word 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // One word of zeros per cycle until the last word, then READY
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    clear_we_s   = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clear_we_s = !reset;
        cnt_next_s = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_WORD) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_next_s = ST_READY;
        cnt_next_s   = '0;
      end
      default: begin
        state_next_s = ST_CLEAR;
        cnt_next_s   = '0;
      end
    endcase
  end

  assign busy_s       = (state_r == ST_CLEAR);
  assign clear_base_s = ADDR_WIDTH'(cnt_r) << LSB_W;
`else
  assign busy_s       = 1'b0;
  assign clear_we_s   = 1'b0;
  assign clear_base_s = '0;
`endif

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign busy   = busy_s;
endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl: a default big-endian instance and a 64-byte little-endian instance.
// With BMEM_CLEAR_EN defined it also exercises the clear sequencer on the small instance.
module tb_byte_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        b_cs, b_wr, b_rd;
  logic [11:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        b_rvalid, b_busy, b_err;
  logic        s_cs, s_wr, s_rd;
  logic [5:0]  s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_rvalid, s_busy, s_err;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n;

`ifdef BMEM_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  byte_mem_ctrl u_big (
    .clk(clk), .reset(reset), .cs(b_cs), .wr(b_wr), .rd(b_rd), .addr(b_addr),
    .wdata(b_wdata), .be(b_be), .rdata(b_rdata), .rvalid(b_rvalid), .busy(b_busy), .err(b_err)
  );

  byte_mem_ctrl #(.ADDR_WIDTH(6), .DATA_BYTES(4), .BIG_ENDIAN(1'b0)) u_small (
    .clk(clk), .reset(reset), .cs(s_cs), .wr(s_wr), .rd(s_rd), .addr(s_addr),
    .wdata(s_wdata), .be(s_be), .rdata(s_rdata), .rvalid(s_rvalid), .busy(s_busy), .err(s_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic b_drive(input logic c, input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] e);
    b_cs = c; b_rd = r; b_wr = w; b_addr = a; b_wdata = d; b_be = e;
  endtask

  task automatic s_drive(input logic c, input logic r, input logic w, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] e);
    s_cs = c; s_rd = r; s_wr = w; s_addr = a; s_wdata = d; s_be = e;
  endtask

  initial begin
    reset = 1'b1;
    b_drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    s_drive(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
    step;
    step;
    check("rst_rdata", b_rdata, 32'h0);
    check("rst_rvalid", {31'h0, b_rvalid}, 32'h0);
    check("rst_err", {31'h0, b_err}, 32'h0);
    check("rst_busy", {31'h0, b_busy}, {31'h0, BUSY_RST});
    reset = 1'b0;

`ifdef BMEM_CLEAR_EN
    s_drive(1'b1, 1'b1, 1'b0, 6'h00, 32'h0, 4'h0);
    step;
    n = 1;
    check("busy_rd_err", {31'h0, s_err}, 32'h1);
    check("busy_rd_rvalid", {31'h0, s_rvalid}, 32'h0);
    s_drive(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
    while (s_busy && n < 40) begin
      step;
      n++;
    end
    check("clear_cycles", n, 32'd16);
    n = 0;
    while (b_busy && n < 2000) begin
      step;
      n++;
    end
    check("big_clear_done", {31'h0, b_busy}, 32'h0);
`endif

    // Big-endian full write then read on the next cycle
    b_drive(1'b1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    step;
    check("wr_rvalid", {31'h0, b_rvalid}, 32'h0);
    check("wr_err", {31'h0, b_err}, 32'h0);
    b_drive(1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    step;
    check("rd_data", b_rdata, 32'hDEADBEEF);
    check("rd_rvalid", {31'h0, b_rvalid}, 32'h1);
    check("rd_err", {31'h0, b_err}, 32'h0);
    b_drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    step;
    check("rvalid_drop", {31'h0, b_rvalid}, 32'h0);
    check("rdata_hold", b_rdata, 32'hDEADBEEF);

    // Byte 0x010 must hold the most significant byte
    b_drive(1'b1, 1'b0, 1'b1, 12'h00C, 32'h00000000, 4'hF);
    step;
    b_drive(1'b1, 1'b1, 1'b0, 12'h00D, 32'h0, 4'h0);
    step;
    check("byte010_data", b_rdata, 32'h000000DE);
    check("byte010_err", {31'h0, b_err}, 32'h1);
    check("byte010_rvalid", {31'h0, b_rvalid}, 32'h1);

    // Partial write with lanes 0 and 2
    b_drive(1'b1, 1'b0, 1'b1, 12'h010, 32'h11223344, 4'b0101);
    step;
    b_drive(1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    step;
    check("partial_data", b_rdata, 32'hDE22BE44);
    check("partial_err", {31'h0, b_err}, 32'h0);

    // Misaligned read wrapping past the top of the array
    b_drive(1'b1, 1'b0, 1'b1, 12'hFFC, 32'h01020304, 4'hF);
    step;
    b_drive(1'b1, 1'b0, 1'b1, 12'h000, 32'hA0B0C0D0, 4'hF);
    step;
    b_drive(1'b1, 1'b1, 1'b0, 12'hFFE, 32'h0, 4'h0);
    step;
    check("wrap_data", b_rdata, 32'h0304A0B0);
    check("wrap_err", {31'h0, b_err}, 32'h1);
    check("wrap_rvalid", {31'h0, b_rvalid}, 32'h1);

    // Read and write together: write wins, read dropped
    b_drive(1'b1, 1'b1, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF);
    step;
    check("conflict_err", {31'h0, b_err}, 32'h1);
    check("conflict_rvalid", {31'h0, b_rvalid}, 32'h0);
    check("conflict_rdata_hold", b_rdata, 32'h0304A0B0);

    // Back-to-back reads keep rvalid high
    b_drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
    step;
    check("conflict_readback", b_rdata, 32'hCAFEF00D);
    check("b2b_rvalid0", {31'h0, b_rvalid}, 32'h1);
    check("b2b_err0", {31'h0, b_err}, 32'h0);
    b_drive(1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    step;
    check("b2b_data1", b_rdata, 32'hDE22BE44);
    check("b2b_rvalid1", {31'h0, b_rvalid}, 32'h1);

    // Deselected request has no effect
    b_drive(1'b0, 1'b1, 1'b1, 12'h010, 32'h00000000, 4'hF);
    step;
    check("cs0_rvalid", {31'h0, b_rvalid}, 32'h0);
    check("cs0_err", {31'h0, b_err}, 32'h0);
    b_drive(1'b1, 1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
    step;
    check("cs0_nowrite", b_rdata, 32'hDE22BE44);
    b_drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);

    // Little-endian instance: full, wrap and partial accesses
    s_drive(1'b1, 1'b0, 1'b1, 6'h04, 32'h11223344, 4'hF);
    step;
    s_drive(1'b1, 1'b0, 1'b1, 6'h3C, 32'h55667788, 4'hF);
    step;
    s_drive(1'b1, 1'b0, 1'b1, 6'h00, 32'h99AABBCC, 4'hF);
    step;
    s_drive(1'b1, 1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    step;
    check("le_data", s_rdata, 32'h11223344);
    s_drive(1'b1, 1'b1, 1'b0, 6'h3E, 32'h0, 4'h0);
    step;
    check("le_wrap_data", s_rdata, 32'hBBCC5566);
    check("le_wrap_err", {31'h0, s_err}, 32'h1);
    s_drive(1'b1, 1'b0, 1'b1, 6'h04, 32'hFFEEDDCC, 4'b1000);
    step;
    s_drive(1'b1, 1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    step;
    check("le_partial", s_rdata, 32'hFF223344);
    s_drive(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
    step;

`ifdef BMEM_CLEAR_EN
    // Reset part-way through a clear restarts the full sequence
    reset = 1'b1;
    step;
    reset = 1'b0;
    repeat (8) step;
    check("midclear_busy", {31'h0, s_busy}, 32'h1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    n = 0;
    while (s_busy && n < 40) begin
      step;
      n++;
    end
    check("midclear_cycles", n, 32'd16);
    s_drive(1'b1, 1'b1, 1'b0, 6'h00, 32'h0, 4'h0);
    step;
    check("clr_rd0_data", s_rdata, 32'h0);
    check("clr_rd0_rvalid", {31'h0, s_rvalid}, 32'h1);
    s_drive(1'b1, 1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    step;
    check("clr_rd4_data", s_rdata, 32'h0);
    check("clr_rd4_rvalid", {31'h0, s_rvalid}, 32'h1);
    s_drive(1'b1, 1'b1, 1'b0, 6'h08, 32'h0, 4'h0);
    step;
    check("clr_rd8_data", s_rdata, 32'h0);
    check("clr_rd8_rvalid", {31'h0, s_rvalid}, 32'h1);
    s_drive(1'b1, 1'b1, 1'b0, 6'h3C, 32'h0, 4'h0);
    step;
    check("clr_rd3c_data", s_rdata, 32'h0);
`else
    // Without the sequencer the array survives reset and requests are taken at once
    reset = 1'b1;
    step;
    step;
    check("rst2_busy", {31'h0, s_busy}, 32'h0);
    check("rst2_rdata", s_rdata, 32'h0);
    reset = 1'b0;
    s_drive(1'b1, 1'b1, 1'b0, 6'h04, 32'h0, 4'h0);
    step;
    check("preserve_data", s_rdata, 32'hFF223344);
    check("preserve_rvalid", {31'h0, s_rvalid}, 32'h1);
`endif
    s_drive(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
    step;
    check("final_rvalid", {31'h0, s_rvalid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
